// File: rtl/traffic_light_monitor.sv
`timescale 1ns/1ps
// traffic_light_monitor: independent checker on the 12-line lamp interface of a 4-way
// traffic light controller; de-glitches the lamps, checks sequence/order/exclusion/liveness.
module traffic_light_monitor #(
    parameter int FILT_LEN    = 4,
    parameter int WDOG_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        R_N,
    input  logic        Y_N,
    input  logic        G_N,
    input  logic        R_E,
    input  logic        Y_E,
    input  logic        G_E,
    input  logic        R_S,
    input  logic        Y_S,
    input  logic        G_S,
    input  logic        R_W,
    input  logic        Y_W,
    input  logic        G_W,
    input  logic        fault_clr,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [1:0]  fault_dir,
    output logic [7:0]  fault_count,
    output logic [1:0]  active_dir,
    output logic        active_valid,
    output logic        phase_done,
    output logic [23:0] green_cycles
);

    localparam int CNT_W = $clog2(FILT_LEN + 1);
    localparam int WD_W  = $clog2(WDOG_CYCLES);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN);
    localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(WDOG_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_ZERO = WD_W'(0);

    localparam logic [11:0] ALL_RED = 12'b100_100_100_100;

    localparam logic [2:0] ASP_RED = 3'b100;
    localparam logic [2:0] ASP_RY  = 3'b110;
    localparam logic [2:0] ASP_GRN = 3'b001;
    localparam logic [2:0] ASP_YEL = 3'b010;

    localparam logic [2:0] C_NONE     = 3'd0;
    localparam logic [2:0] C_CONFLICT = 3'd1;
    localparam logic [2:0] C_ASPECT   = 3'd2;
    localparam logic [2:0] C_TRANS    = 3'd3;
    localparam logic [2:0] C_ORDER    = 3'd4;
    localparam logic [2:0] C_STALL    = 3'd5;

    function automatic logic [2:0] asp_of(input logic [11:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    asp_of = v[11:9];
            2'd1:    asp_of = v[8:6];
            2'd2:    asp_of = v[5:3];
            default: asp_of = v[2:0];
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] a);
        is_legal = (a == ASP_RED) || (a == ASP_RY) || (a == ASP_GRN) || (a == ASP_YEL);
    endfunction

    function automatic logic legal_step(input logic [2:0] p, input logic [2:0] c);
        case (p)
            ASP_RED: legal_step = (c == ASP_RY);
            ASP_RY:  legal_step = (c == ASP_GRN);
            ASP_GRN: legal_step = (c == ASP_YEL);
            ASP_YEL: legal_step = (c == ASP_RED);
            default: legal_step = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] first_idx(input logic [3:0] m);
        if (m[0])      first_idx = 2'd0;
        else if (m[1]) first_idx = 2'd1;
        else if (m[2]) first_idx = 2'd2;
        else           first_idx = 2'd3;
    endfunction

    // Approach index N,E,S,W maps to the Gray-style direction code 00,01,11,10.
    function automatic logic [1:0] dir_code(input logic [1:0] idx);
        case (idx)
            2'd0:    dir_code = 2'b00;
            2'd1:    dir_code = 2'b01;
            2'd2:    dir_code = 2'b11;
            default: dir_code = 2'b10;
        endcase
    endfunction

    logic [11:0]      sync1_q, sync1_d, sync2_q, sync2_d, cand_q, cand_d;
    logic [11:0]      filt_q, filt_d, prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [1:0]       last_q, last_d;
    logic [23:0]      gtmr_q, gtmr_d;
    logic             fault_q, fault_d, active_valid_q, active_valid_d, phase_done_q, phase_done_d;
    logic [2:0]       fault_code_q, fault_code_d;
    logic [1:0]       fault_dir_q, fault_dir_d, active_dir_q, active_dir_d;
    logic [7:0]       fault_count_q, fault_count_d;
    logic [23:0]      green_cycles_q, green_cycles_d;

    logic             chg_s, multi_s, one_hot_s, counting_s, stall_s, det_s, order_bad_s;
    logic [3:0]       nonred_s, bad_asp_s, bad_trans_s, start_s, yel_red_s, grn_yel_s;
    logic [1:0]       last_s, order_idx_s, act_idx_s, det_dir_s;
    logic [2:0]       det_code_s;

    // Synchroniser and stability filter: cnt_q is how long cand_q has been seen unchanged.
    always_comb begin
        sync1_d = {R_N, Y_N, G_N, R_E, Y_E, G_E, R_S, Y_S, G_S, R_W, Y_W, G_W};
        sync2_d = sync1_q;
        cand_d  = sync2_q;
        prev_d  = filt_q;
        if (sync2_q != cand_q) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        if (cnt_q == CNT_MAX) begin
            filt_d = cand_q;
        end else begin
            filt_d = filt_q;
        end
    end

    // Per-approach decode of the accepted vector against the previous one.
    always_comb begin
        chg_s       = (filt_q != prev_q);
        nonred_s    = 4'b0000;
        bad_asp_s   = 4'b0000;
        bad_trans_s = 4'b0000;
        start_s     = 4'b0000;
        yel_red_s   = 4'b0000;
        grn_yel_s   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            nonred_s[i] = (asp_of(filt_q, 2'(i)) != ASP_RED);
            if (chg_s) begin
                // An approach that just moved is judged on its transition, one holding still on its pattern.
                if (asp_of(filt_q, 2'(i)) != asp_of(prev_q, 2'(i))) begin
                    bad_trans_s[i] = !legal_step(asp_of(prev_q, 2'(i)), asp_of(filt_q, 2'(i)));
                end else begin
                    bad_asp_s[i] = !is_legal(asp_of(filt_q, 2'(i)));
                end
                start_s[i]   = (asp_of(prev_q, 2'(i)) == ASP_RED) && (asp_of(filt_q, 2'(i)) == ASP_RY);
                yel_red_s[i] = (asp_of(prev_q, 2'(i)) == ASP_YEL) && (asp_of(filt_q, 2'(i)) == ASP_RED);
                grn_yel_s[i] = (asp_of(prev_q, 2'(i)) == ASP_GRN) && (asp_of(filt_q, 2'(i)) == ASP_YEL);
            end else begin
                bad_trans_s[i] = 1'b0;
            end
        end
        multi_s    = ((nonred_s & (nonred_s - 4'b0001)) != 4'b0000);
        one_hot_s  = (nonred_s != 4'b0000) && !multi_s;
        act_idx_s  = first_idx(nonred_s);
        counting_s = one_hot_s && (asp_of(filt_q, act_idx_s) == ASP_GRN);
    end

    // Service order: walk the starts in N>E>S>W order so last_served follows each one.
    always_comb begin
        last_s      = last_q;
        order_bad_s = 1'b0;
        order_idx_s = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (start_s[i]) begin
                if ((2'(i) != (last_s + 2'd1)) && !order_bad_s) begin
                    order_bad_s = 1'b1;
                    order_idx_s = 2'(i);
                end else begin
                    order_bad_s = order_bad_s;
                end
                last_s = 2'(i);
            end else begin
                last_s = last_s;
            end
        end
        last_d = last_s;
    end

    // Watchdog and fault arbitration: lowest code wins, then N>E>S>W.
    always_comb begin
        stall_s = !chg_s && (wdog_q == WD_MAX);
        if (chg_s || stall_s) begin
            wdog_d = WD_ZERO;
        end else begin
            wdog_d = wdog_q + WD_ONE;
        end
        det_s      = 1'b1;
        det_code_s = C_NONE;
        det_dir_s  = 2'b00;
        if (chg_s && multi_s) begin
            det_code_s = C_CONFLICT;
            det_dir_s  = dir_code(first_idx(nonred_s));
        end else if (bad_asp_s != 4'b0000) begin
            det_code_s = C_ASPECT;
            det_dir_s  = dir_code(first_idx(bad_asp_s));
        end else if (bad_trans_s != 4'b0000) begin
            det_code_s = C_TRANS;
            det_dir_s  = dir_code(first_idx(bad_trans_s));
        end else if (order_bad_s) begin
            det_code_s = C_ORDER;
            det_dir_s  = dir_code(order_idx_s);
        end else if (stall_s) begin
            det_code_s = C_STALL;
        end else begin
            det_s = 1'b0;
        end
    end

    // Sticky fault state, activity reporting and green timer.
    always_comb begin
        fault_d       = fault_q;
        fault_code_d  = fault_code_q;
        fault_dir_d   = fault_dir_q;
        fault_count_d = fault_count_q;
        if (fault_clr) begin
            fault_d       = det_s;
            fault_code_d  = det_code_s;
            fault_dir_d   = det_dir_s;
            fault_count_d = det_s ? 8'd1 : 8'd0;
        end else begin
            if (det_s && !fault_q) begin
                fault_d      = 1'b1;
                fault_code_d = det_code_s;
                fault_dir_d  = det_dir_s;
            end else begin
                fault_d = fault_q;
            end
            if (det_s && (fault_count_q != 8'hFF)) begin
                fault_count_d = fault_count_q + 8'd1;
            end else begin
                fault_count_d = fault_count_q;
            end
        end
        active_valid_d = one_hot_s;
        active_dir_d   = one_hot_s ? dir_code(act_idx_s) : active_dir_q;
        phase_done_d   = (yel_red_s != 4'b0000);
        if (counting_s) begin
            gtmr_d = (gtmr_q == 24'hFF_FFFF) ? gtmr_q : gtmr_q + 24'd1;
        end else begin
            gtmr_d = 24'd0;
        end
        green_cycles_d = (grn_yel_s != 4'b0000) ? gtmr_q : green_cycles_q;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q        <= ALL_RED;
            sync2_q        <= ALL_RED;
            cand_q         <= ALL_RED;
            filt_q         <= ALL_RED;
            prev_q         <= ALL_RED;
            cnt_q          <= CNT_MAX;
            wdog_q         <= WD_ZERO;
            last_q         <= 2'd3;
            gtmr_q         <= 24'd0;
            fault_q        <= 1'b0;
            fault_code_q   <= C_NONE;
            fault_dir_q    <= 2'b00;
            fault_count_q  <= 8'd0;
            active_dir_q   <= 2'b00;
            active_valid_q <= 1'b0;
            phase_done_q   <= 1'b0;
            green_cycles_q <= 24'd0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            cand_q         <= cand_d;
            filt_q         <= filt_d;
            prev_q         <= prev_d;
            cnt_q          <= cnt_d;
            wdog_q         <= wdog_d;
            last_q         <= last_d;
            gtmr_q         <= gtmr_d;
            fault_q        <= fault_d;
            fault_code_q   <= fault_code_d;
            fault_dir_q    <= fault_dir_d;
            fault_count_q  <= fault_count_d;
            active_dir_q   <= active_dir_d;
            active_valid_q <= active_valid_d;
            phase_done_q   <= phase_done_d;
            green_cycles_q <= green_cycles_d;
        end
    end

    assign fault        = fault_q;
    assign fault_code   = fault_code_q;
    assign fault_dir    = fault_dir_q;
    assign fault_count  = fault_count_q;
    assign active_dir   = active_dir_q;
    assign active_valid = active_valid_q;
    assign phase_done   = phase_done_q;
    assign green_cycles = green_cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
`timescale 1ns/1ps
// Directed self-checking bench for traffic_light_monitor (FILT_LEN=4, WDOG_CYCLES=100).
module tb_traffic_light_monitor;

    localparam int FL = 4;
    localparam int WD = 100;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] RY  = 3'b110;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] YEL = 3'b010;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fault_clr = 1'b0;
    logic [11:0] lamps = 12'b100_100_100_100;
    logic        fault, active_valid, phase_done;
    logic [2:0]  fault_code;
    logic [1:0]  fault_dir, active_dir;
    logic [7:0]  fault_count;
    logic [23:0] green_cycles;

    int errors = 0;
    int checks = 0;
    int pd_high = 0;
    int pd_rise = 0;
    logic pd_last = 1'b0;

    always #5 clk = ~clk;

    traffic_light_monitor #(.FILT_LEN(FL), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .reset(reset),
        .R_N(lamps[11]), .Y_N(lamps[10]), .G_N(lamps[9]),
        .R_E(lamps[8]),  .Y_E(lamps[7]),  .G_E(lamps[6]),
        .R_S(lamps[5]),  .Y_S(lamps[4]),  .G_S(lamps[3]),
        .R_W(lamps[2]),  .Y_W(lamps[1]),  .G_W(lamps[0]),
        .fault_clr(fault_clr), .fault(fault), .fault_code(fault_code), .fault_dir(fault_dir),
        .fault_count(fault_count), .active_dir(active_dir), .active_valid(active_valid),
        .phase_done(phase_done), .green_cycles(green_cycles)
    );

    // phase_done pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (phase_done) pd_high++;
        if (phase_done && !pd_last) pd_rise++;
        pd_last = phase_done;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_asp(input int idx, input logic [2:0] a);
        lamps[11 - 3*idx -: 3] = a;
    endtask

    task automatic do_reset();
        lamps = 12'b100_100_100_100;
        fault_clr = 1'b0;
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got=%0b exp=0", fault); end
        checks++; if (fault_code !== 3'd0) begin errors++; $display("FAIL rst_code got=%0d exp=0", fault_code); end
        checks++; if (fault_dir !== 2'b00) begin errors++; $display("FAIL rst_dir got=%b exp=00", fault_dir); end
        checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", fault_count); end
        checks++; if (active_dir !== 2'b00) begin errors++; $display("FAIL rst_active_dir got=%b exp=00", active_dir); end
        checks++; if (active_valid !== 1'b0) begin errors++; $display("FAIL rst_active_valid got=%0b exp=0", active_valid); end
        checks++; if (phase_done !== 1'b0) begin errors++; $display("FAIL rst_phase_done got=%0b exp=0", phase_done); end
        checks++; if (green_cycles !== 24'd0) begin errors++; $display("FAIL rst_green got=%0d exp=0", green_cycles); end
        tick(20);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL idle_fault got=%0b exp=0", fault); end
    endtask

    task automatic test_latency();
        do_reset();
        set_asp(0, RY);
        tick(FL + 3);
        checks++; if (active_valid !== 1'b0) begin errors++; $display("FAIL lat_early got=%0b exp=0", active_valid); end
        tick(1);
        checks++; if (active_valid !== 1'b1) begin errors++; $display("FAIL lat_edge got=%0b exp=1", active_valid); end
        checks++; if (active_dir !== 2'b00) begin errors++; $display("FAIL lat_dir got=%b exp=00", active_dir); end
    endtask

    task automatic test_legal_cycle();
        logic [1:0] exp_dir [4];
        int base_rise, base_high;
        exp_dir[0] = 2'b00; exp_dir[1] = 2'b01; exp_dir[2] = 2'b11; exp_dir[3] = 2'b10;
        do_reset();
        base_rise = pd_rise;
        base_high = pd_high;
        for (int d = 0; d < 4; d++) begin
            set_asp(d, RY);  tick(10);
            set_asp(d, GRN); tick(50);
            checks++; if (active_dir !== exp_dir[d] || active_valid !== 1'b1) begin errors++; $display("FAIL legal_active[%0d] got=%b/%0b exp=%b/1", d, active_dir, active_valid, exp_dir[d]); end
            set_asp(d, YEL); tick(10);
            checks++; if (green_cycles < 24'(50 - FL - 2) || green_cycles > 24'(50 + FL + 2)) begin errors++; $display("FAIL legal_green[%0d] got=%0d exp=50+-%0d", d, green_cycles, FL + 2); end
            set_asp(d, RED); tick(10);
        end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL legal_fault got=%0b code=%0d exp=0", fault, fault_code); end
        checks++; if (pd_rise - base_rise != 4) begin errors++; $display("FAIL legal_pd_pulses got=%0d exp=4", pd_rise - base_rise); end
        checks++; if (pd_high - base_high != 4) begin errors++; $display("FAIL legal_pd_width got=%0d exp=4", pd_high - base_high); end
        checks++; if (active_valid !== 1'b0 || active_dir !== 2'b10) begin errors++; $display("FAIL legal_hold got=%0b/%b exp=0/10", active_valid, active_dir); end
    endtask

    task automatic test_glitch();
        do_reset();
        lamps[6] = 1'b1; tick(3); lamps[6] = 1'b0; tick(12);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL glitch_short_fault got=%0b exp=0", fault); end
        checks++; if (active_valid !== 1'b0) begin errors++; $display("FAIL glitch_short_active got=%0b exp=0", active_valid); end
        lamps[6] = 1'b1; tick(4); lamps[6] = 1'b0; tick(12);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL glitch_long_fault got=%0b exp=1", fault); end
        checks++; if (fault_code !== 3'd3) begin errors++; $display("FAIL glitch_long_code got=%0d exp=3", fault_code); end
        checks++; if (fault_dir !== 2'b01) begin errors++; $display("FAIL glitch_long_dir got=%b exp=01", fault_dir); end
    endtask

    task automatic test_conflict();
        do_reset();
        set_asp(0, RY);  tick(10);
        set_asp(0, GRN); tick(10);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL conf_pre got=%0b exp=0", fault); end
        set_asp(2, RY);  tick(10);
        checks++; if (fault_code !== 3'd1) begin errors++; $display("FAIL conf_code got=%0d exp=1", fault_code); end
        checks++; if (fault_dir !== 2'b00) begin errors++; $display("FAIL conf_dir got=%b exp=00", fault_dir); end
        checks++; if (fault_count !== 8'd1) begin errors++; $display("FAIL conf_count got=%0d exp=1", fault_count); end
        set_asp(2, 3'b000); tick(10);
        checks++; if (fault_code !== 3'd1) begin errors++; $display("FAIL conf_sticky got=%0d exp=1", fault_code); end
        checks++; if (fault_count !== 8'd2) begin errors++; $display("FAIL conf_count2 got=%0d exp=2", fault_count); end
    endtask

    task automatic test_order();
        do_reset();
        set_asp(1, RY); tick(10);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL order_fault got=%0b exp=1", fault); end
        checks++; if (fault_code !== 3'd4) begin errors++; $display("FAIL order_code got=%0d exp=4", fault_code); end
        checks++; if (fault_dir !== 2'b01) begin errors++; $display("FAIL order_dir got=%b exp=01", fault_dir); end
    endtask

    task automatic test_stall_clear();
        do_reset();
        tick(WD - 1);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL stall_early got=%0b exp=0", fault); end
        tick(1);
        checks++; if (fault !== 1'b1 || fault_code !== 3'd5) begin errors++; $display("FAIL stall_code got=%0b/%0d exp=1/5", fault, fault_code); end
        checks++; if (fault_dir !== 2'b00 || fault_count !== 8'd1) begin errors++; $display("FAIL stall_dir_count got=%b/%0d exp=00/1", fault_dir, fault_count); end
        tick(WD - 1);
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
        checks++; if (fault !== 1'b1 || fault_code !== 3'd5) begin errors++; $display("FAIL clr_same_cycle got=%0b/%0d exp=1/5", fault, fault_code); end
        checks++; if (fault_count !== 8'd1) begin errors++; $display("FAIL clr_same_count got=%0d exp=1", fault_count); end
        tick(5);
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
        checks++; if (fault !== 1'b0 || fault_code !== 3'd0 || fault_count !== 8'd0) begin errors++; $display("FAIL clr_plain got=%0b/%0d/%0d exp=0/0/0", fault, fault_code, fault_count); end
    endtask

    task automatic test_reset_mid_phase();
        int base_rise;
        do_reset();
        set_asp(0, RY);  tick(10);
        set_asp(0, GRN); tick(10);
        checks++; if (active_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got=%0b exp=1", active_valid); end
        set_asp(0, YEL); tick(1);
        reset = 1'b0; lamps = 12'b100_100_100_100; tick(1); reset = 1'b1;
        checks++; if (fault !== 1'b0 || active_valid !== 1'b0 || active_dir !== 2'b00) begin errors++; $display("FAIL mid_rst_out got=%0b/%0b/%b exp=0/0/00", fault, active_valid, active_dir); end
        checks++; if (green_cycles !== 24'd0 || fault_count !== 8'd0 || phase_done !== 1'b0) begin errors++; $display("FAIL mid_rst_misc got=%0d/%0d/%0b exp=0/0/0", green_cycles, fault_count, phase_done); end
        tick(12);
        base_rise = pd_rise;
        set_asp(0, RY);  tick(10);
        checks++; if (fault !== 1'b0 || active_valid !== 1'b1 || active_dir !== 2'b00) begin errors++; $display("FAIL mid_n_first got=%0b/%0b/%b exp=0/1/00", fault, active_valid, active_dir); end
        set_asp(0, GRN); tick(10);
        set_asp(0, YEL); tick(10);
        set_asp(0, RED); tick(10);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL mid_fault got=%0b code=%0d exp=0", fault, fault_code); end
        checks++; if (pd_rise - base_rise != 1) begin errors++; $display("FAIL mid_pd got=%0d exp=1", pd_rise - base_rise); end
        checks++; if (green_cycles < 24'(10 - FL - 2) || green_cycles > 24'(10 + FL + 2)) begin errors++; $display("FAIL mid_green got=%0d exp=10+-%0d", green_cycles, FL + 2); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_legal_cycle();
        test_glitch();
        test_conflict();
        test_order();
        test_stall_clear();
        test_reset_mid_phase();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Independent lamp-output checker that sits on the receiving end of the 12-signal lamp interface driven by the 4-way traffic light controller. It synchronises and de-glitches the R/Y/G lines of all four approaches, decodes each approach's aspect, and checks the lamp sequence, service order, mutual exclusion and liveness. Detected faults are latched as a sticky code for the safety/diagnostic layer, and per-phase events and green duration are reported.

## Interface
- FILT_LEN, 4: consecutive identical samples required before a lamp vector is accepted (≥1)
- WDOG_CYCLES, 1_000_000: cycles without any accepted lamp change before a stall fault (≥2)
- clk  in  1  single system clock
- reset  in  1  synchronous, active-low reset
- R_N, Y_N, G_N, R_E, Y_E, G_E, R_S, Y_S, G_S, R_W, Y_W, G_W  in  1 each  lamp lines, asynchronous to clk
- fault_clr  in  1  synchronous clear of sticky fault state
- fault  out  1  sticky fault flag
- fault_code  out  3  first fault: 0 none, 1 conflict, 2 illegal aspect, 3 illegal transition, 4 order, 5 stall
- fault_dir  out  2  approach of first fault (N=00, E=01, S=11, W=10); 00 for codes 0 and 5
- fault_count  out  8  saturating count of fault-detection cycles
- active_dir  out  2  approach currently not at RED
- active_valid  out  1  exactly one approach not at RED
- phase_done  out  1  one-cycle pulse when an approach goes YEL→RED
- green_cycles  out  24  saturating length of the last completed GRN aspect in clk cycles

## Operation
- Front end: a 2-flop synchroniser on all 12 lines, then a stability filter. The filtered vector `filt` updates only after the synchronised vector has held one value for FILT_LEN consecutive cycles. Shorter pulses are discarded.
- Aspect per approach, as {R,Y,G}: 100 RED, 110 RED_YEL, 001 GRN, 010 YEL. All other patterns are illegal (includes dark 000).
- Legal per-approach transitions: RED→RED_YEL→GRN→YEL→RED. No change is also legal. Every other change is an illegal transition.
- Order: each RED→RED_YEL must occur on next(last_served), following the cycle N→E→S→W→N. On success last_served updates to that approach. On failure an order fault is raised and last_served still updates.
- Conflict: more than one approach with a non-RED aspect in `filt`.
- Stall: the watchdog counter clears on any `filt` change and otherwise increments. Reaching WDOG_CYCLES−1 raises a stall fault and restarts the count from 0.
- Checks run once per `filt` update. Stall is checked every cycle.
- If several faults occur in one cycle, the lowest code wins. If several approaches are involved, the approach priority is N>E>S>W.
- Fault latching:
  - The first fault sets fault, fault_code and fault_dir. These are not overwritten until fault_clr.
  - fault_count increments once per cycle in which any fault is detected, saturating at 255.
  - fault_clr zeroes fault, fault_code, fault_dir and fault_count. If a fault is detected in the same cycle as fault_clr, the new fault is latched and fault_count = 1.
- Green timer: counts cycles while the active approach is at GRN in `filt`. On GRN→YEL it loads green_cycles, saturating at 2^24−1.
- active_dir holds its last value when active_valid = 0.

## Timing
- Reset (reset=0 at a clk edge) values:
  - Outputs: fault=0, fault_code=0, fault_dir=00, fault_count=0, active_dir=00, active_valid=0, phase_done=0, green_cycles=0.
  - Internal state: `filt` = all RED (100 on every approach), synchroniser and filter primed to all RED, last_served=W so N is expected first, watchdog=0.
- Reset mid-operation discards all history. It takes priority over fault_clr.
- Latency:
  - A raw change first sampled at edge 0 that stays stable reaches `filt` at edge FILT_LEN+2.
  - fault, active_*, phase_done and green_cycles reflect it at edge FILT_LEN+3.
- phase_done is high for exactly one cycle per YEL→RED.
- All outputs are registered. Nothing is combinational from the inputs.

## Test plan
- Legal cycle:
  - Stimulus: drive N 100→110→001→010→100 with every dwell ≥ FILT_LEN+2, then the same for E, S and W. GRN held 50 cycles.
  - Response: fault=0; phase_done pulses 4 times; green_cycles=50 after each phase, within ±FILT_LEN+2 of the stimulus hold; active_dir follows 00,01,11,10.
- Glitch rejection: with FILT_LEN=4, pulse G_E high for 3 cycles during all-RED → no `filt` change, fault=0. Hold it for 4 cycles → fault_code=3, fault_dir=01.
- Conflict with priority: N at GRN, then S goes to RED_YEL → fault_code=1, fault_dir=00, fault_count=1. A further illegal aspect on S leaves fault_code=1 and makes fault_count=2.
- Order fault: after reset, E performs RED→RED_YEL first → fault_code=4, fault_dir=01.
- Stall plus clear:
  - Stimulus: WDOG_CYCLES=100, hold all RED.
  - Response: fault_code=5 at cycle 99 after the last change.
  - Follow-up: assert fault_clr at the same cycle as the next stall detection → fault stays 1 with code 5 and fault_count=1.
- Reset mid-phase: with N at GRN, pulse reset=0 for one cycle → all outputs at reset values, next expected approach N, no fault raised while N returns to RED through YEL. The transition is checked against the all-RED reset vector, so the bench must drive RED before release.
